// File: rtl/max_pool_row_pair_feeder.sv
// -----------------------------------------------------------------------------
// max_pool_row_pair_feeder
//
// Collects two consecutive image rows (raster order) into one packed vector
// and presents them to a downstream 2x2 max-pool stage with a valid/ready
// handshake. While the row pair is being presented, no further pixels are
// accepted.
//
// Parameters
//   DATA_BITS  width of one channel element
//   D          channels per pixel
//   W          pixels per row (even)
//   H          rows per frame (even)
//
// Ports
//   clk        single clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   upstream pixel valid
//   in_ready   block accepts a pixel this cycle (FILL state)
//   in_data    one pixel, channel c at [c*DATA_BITS +: DATA_BITS]
//   out_valid  row-pair vector valid (HOLD state)
//   out_ready  downstream accepts the vector
//   out_data   upper row at (c*W+j), lower row at (D*W+c*W+j), in DATA_BITS units
//   out_last   final row pair of the frame, qualified by out_valid
// -----------------------------------------------------------------------------
module max_pool_row_pair_feeder #(
    parameter int DATA_BITS = 32,
    parameter int D         = 1,
    parameter int W         = 92,
    parameter int H         = 92
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [D*DATA_BITS-1:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*W*D*DATA_BITS-1:0]   out_data,
    output logic                         out_last
);

    localparam int COL_BITS  = (W > 1) ? $clog2(W) : 1;
    localparam int PAIRS     = H / 2;
    localparam int PAIR_BITS = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int VEC_BITS  = 2 * W * D * DATA_BITS;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [COL_BITS-1:0]    col;
    logic                   row_sel;
    logic [PAIR_BITS-1:0]   pair_cnt;
    logic [VEC_BITS-1:0]    pair_buf;

    logic                   accept;
    logic                   handshake;
    logic                   col_last;
    logic                   pair_last;
    int                     wr_slot;

    assign accept    = in_valid && (state == FILL);
    assign handshake = out_ready && (state == HOLD);
    assign col_last  = (col == COL_BITS'(W - 1));
    assign pair_last = (pair_cnt == PAIR_BITS'(PAIRS - 1));

    // Linear slot index in raster order: 0..W-1 upper row, W..2W-1 lower row.
    assign wr_slot = int'(row_sel) * W + int'(col);

    // NOTE: always_comb assigns every output a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (accept && row_sel && col_last) state_nxt = HOLD;
            HOLD: if (out_ready)                     state_nxt = FILL;
            default:                                 state_nxt = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FILL;
            col      <= '0;
            row_sel  <= 1'b0;
            pair_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (col_last) begin
                    col     <= '0;
                    row_sel <= ~row_sel;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (handshake) begin
                col      <= '0;
                row_sel  <= 1'b0;
                pair_cnt <= pair_last ? '0 : pair_cnt + 1'b1;
            end
        end
    end

    // NOTE: the row-pair buffer is reset even though it is plain storage,
    // because out_data is visible and must read zero while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_buf <= '0;
        end else if (accept) begin
            // Constant-index decode keeps every part-select static.
            for (int s = 0; s < 2 * W; s++) begin
                if (wr_slot == s) begin
                    for (int c = 0; c < D; c++) begin
                        pair_buf[((s / W) * D * W + c * W + (s % W)) * DATA_BITS +: DATA_BITS]
                            <= in_data[c * DATA_BITS +: DATA_BITS];
                    end
                end
            end
        end
    end

    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);
    assign out_last  = (state == HOLD) && pair_last;
    assign out_data  = pair_buf;

endmodule

// File: tb/tb_max_pool_row_pair_feeder.sv
// -----------------------------------------------------------------------------
// tb_max_pool_row_pair_feeder
//
// Bench for max_pool_row_pair_feeder with W=4, H=4, DATA_BITS=8. The D=1
// instance is tracked every cycle by a queue-based model of the valid/ready
// contract (accepted pixels, pending vector, pairs delivered); a D=2 instance
// checks channel placement in the packed output.
// -----------------------------------------------------------------------------
module tb_max_pool_row_pair_feeder;

    localparam int DB = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk;
    logic          reset_n;

    // D = 1 instance
    logic          iv, ir, ov, orr, ol;
    logic [7:0]    id;
    logic [63:0]   od;

    // D = 2 instance
    logic          iv2, ir2, ov2, or2, ol2;
    logic [15:0]   id2;
    logic [127:0]  od2;

    int            total;
    int            bad;

    // Reference model state
    logic [7:0]    pix_q[$];
    bit            pending;
    int            pairs_done;

    max_pool_row_pair_feeder #(.DATA_BITS(DB), .D(1), .W(W), .H(H)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv), .in_ready(ir), .in_data(id),
        .out_valid(ov), .out_ready(orr), .out_data(od), .out_last(ol)
    );

    max_pool_row_pair_feeder #(.DATA_BITS(DB), .D(2), .W(W), .H(H)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_last(ol2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected vector: accepted pixels laid out in raster order (D = 1).
    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < pix_q.size(); k++) v[k * DB +: DB] = pix_q[k];
        return v;
    endfunction

    // One clock: drive inputs, check outputs against the model, advance.
    task automatic cyc(input bit v, input logic [7:0] d, input bit r);
        iv  = v;
        id  = d;
        orr = r;
        check("in_ready", ir, !pending);
        check("out_valid", ov, pending);
        if (pending) begin
            check("out_data", od, model_vec());
            check("out_last", ol, (pairs_done % (H / 2)) == (H / 2 - 1));
        end
        @(posedge clk);
        if (!pending && v) begin
            pix_q.push_back(d);
            if (pix_q.size() == 2 * W) pending = 1'b1;
        end else if (pending && r) begin
            pending = 1'b0;
            pix_q.delete();
            pairs_done++;
        end
        #1;
    endtask

    task automatic send_pair(input int base, input bit gap);
        for (int k = 0; k < 2 * W; k++) begin
            if (gap) cyc(1'b0, 8'hAA, 1'b0);
            cyc(1'b1, 8'(base + k), 1'b0);
        end
    endtask

    task automatic model_reset();
        pix_q.delete();
        pending    = 1'b0;
        pairs_done = 0;
    endtask

    initial begin
        logic [127:0] exp2;

        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        iv = 1'b0; id = '0; orr = 1'b0;
        iv2 = 1'b0; id2 = '0; or2 = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst_in_ready", ir, 1'b1);
        check("rst_out_valid", ov, 1'b0);
        check("rst_out_last", ol, 1'b0);
        check("rst_out_data", od, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous pair 1..8, valid one cycle after the last pixel
        send_pair(1, 1'b0);
        check("p1_valid", ov, 1'b1);
        check("p1_data", od, 64'h0807060504030201);
        check("p1_last", ol, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);

        // Second pair is the last of the frame
        send_pair(9, 1'b0);
        check("p2_data", od, 64'h100F0E0D0C0B0A09);
        check("p2_last", ol, 1'b1);

        // Back-pressure: HOLD ignores incoming pixels
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hFF, 1'b0);
        check("hold_data", od, 64'h100F0E0D0C0B0A09);
        check("hold_in_ready", ir, 1'b0);
        cyc(1'b1, 8'hFF, 1'b1);
        check("after_hs_ready", ir, 1'b1);
        cyc(1'b1, 8'hFF, 1'b0);          // 0xFF accepted as upper col 0
        for (int k = 1; k < 2 * W; k++) cyc(1'b1, 8'(k + 1), 1'b0);
        check("p3_data", od, 64'h08070605040302FF);
        check("p3_last", ol, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);

        // Gapped in_valid gives the same vector
        send_pair(1, 1'b1);
        check("gap_valid", ov, 1'b1);
        check("gap_data", od, 64'h0807060504030201);
        cyc(1'b0, 8'h00, 1'b1);

        // Reset mid-fill discards the partial pair
        for (int k = 1; k <= 5; k++) cyc(1'b1, 8'(k), 1'b0);
        iv = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready", ir, 1'b1);
        check("mid_rst_out_valid", ov, 1'b0);
        check("mid_rst_out_last", ol, 1'b0);
        check("mid_rst_out_data", od, 64'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", ov, 1'b0);
        send_pair(21, 1'b0);
        check("post_rst_data", od, 64'h1C1B1A1918171615);
        check("post_rst_last", ol, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);

        // Two-channel placement
        iv = 1'b0;
        orr = 1'b0;
        for (int k = 1; k <= 2 * W; k++) begin
            iv2 = 1'b1;
            id2 = {8'(k + 100), 8'(k)};
            @(posedge clk);
            #1;
        end
        iv2 = 1'b0;
        exp2 = '0;
        for (int k = 1; k <= 2 * W; k++) begin
            int row, j;
            row = (k - 1) / W;
            j   = (k - 1) % W;
            exp2[(row * 2 * W + j) * DB +: DB]     = 8'(k);
            exp2[(row * 2 * W + W + j) * DB +: DB] = 8'(k + 100);
        end
        check("d2_valid", ov2, 1'b1);
        check("d2_in_ready", ir2, 1'b0);
        check("d2_data", od2, exp2);
        check("d2_last", ol2, 1'b0);
        or2 = 1'b1;
        @(posedge clk);
        #1;
        or2 = 1'b0;
        check("d2_after_hs", ir2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
